// File: rtl/vga_scan_controller.sv
// 640x480@60Hz VGA scan generator with 5x5 upscaled 128x96 VRAM readout.
// Colour and sync outputs trail the scan counters by exactly one pixel.
module vga_scan_controller #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned SCALE   = 5,
    parameter int unsigned IMG_W   = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [13:0] addr,
    input  logic        pix_r,
    input  logic        pix_g,
    input  logic        pix_b,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [2:0] SUB_LAST   = 3'(SCALE - 1);
    localparam logic [6:0] H_IMG_LAST = 7'(IMG_W - 1);
    localparam logic [6:0] V_IMG_LAST = 7'(V_VIS / SCALE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [2:0] h_sub_q, h_sub_d, v_sub_q, v_sub_d;
    logic [6:0] h_img_q, h_img_d, v_img_q, v_img_d;
    logic       tick, active, frame_wrap;

    assign tick       = (div_q == DIV_LAST);
    assign active     = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign frame_wrap = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign addr       = {v_img_q, h_img_q};

    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        h_sub_d = h_sub_q;
        h_img_d = h_img_q;
        v_sub_d = v_sub_q;
        v_img_d = v_img_q;
        if (tick) begin
            h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
            if (h_cnt_q < H_VIS_C) begin
                if (h_sub_q == SUB_LAST) begin
                    h_sub_d = 3'd0;
                    h_img_d = (h_img_q == H_IMG_LAST) ? 7'd0 : h_img_q + 7'd1;
                end else begin
                    h_sub_d = h_sub_q + 3'd1;
                end
            end
            if (h_cnt_q == H_LAST) begin
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                    v_sub_d = 3'd0;
                    v_img_d = 7'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                    // Image row stepping only during visible lines; held in vertical blanking.
                    if (v_cnt_q < V_VIS_C) begin
                        if (v_sub_q == SUB_LAST) begin
                            v_sub_d = 3'd0;
                            v_img_d = (v_img_q == V_IMG_LAST) ? 7'd0 : v_img_q + 7'd1;
                        end else begin
                            v_sub_d = v_sub_q + 3'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            h_sub_q     <= 3'd0;
            h_img_q     <= 7'd0;
            v_sub_q     <= 3'd0;
            v_img_q     <= 7'd0;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            h_sub_q     <= h_sub_d;
            h_img_q     <= h_img_d;
            v_sub_q     <= v_sub_d;
            v_img_q     <= v_img_d;
            frame_start <= tick && frame_wrap;
            // Outputs reflect the counter state that produced the VRAM data now on pix_*.
            if (tick) begin
                vga_r     <= active ? {4{pix_r}} : 4'h0;
                vga_g     <= active ? {4{pix_g}} : 4'h0;
                vga_b     <= active ? {4{pix_b}} : 4'h0;
                vga_hsync <= !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
                vga_vsync <= !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
            end
        end
    end

endmodule
